ctrl_decode_pipe: RTL and testbench

Registered, flow-controlled successor to the combinational RV32 control decoder. Accepts one instruction per cycle from fetch over a valid/ready handshake and decodes it into the control bundle. Presents the bundle one cycle later in an ID/EX output register, with back-pressure, flush, illegal-instruction flagging, an optional M-extension ALU mode and a FENCE drain stall.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decode_comb.sv | 64 ++++++
 rtl/ctrl_decode_pipe.sv | 102 ++++++++++
 tb/tb_ctrl_decode_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU encodings, control bundle and FSM states
package ctrl_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALUOP_OP    = 4'b0000;
  localparam logic [3:0] ALUOP_ADDR  = 4'b0001;
  localparam logic [3:0] ALUOP_STORE = 4'b0010;
  localparam logic [3:0] ALUOP_LOAD  = 4'b0011;
  localparam logic [3:0] ALUOP_SYS   = 4'b0100;
  localparam logic [3:0] ALUOP_SUB   = 4'b0101;
  localparam logic [3:0] ALUOP_MEXT  = 4'b1000;

  typedef struct packed {
    logic [1:0] imsel;
    logic       jump;
    logic       branch;
    logic       alusrc1;
    logic       alusrc2;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       h_sel;
    logic       csr;
    logic       fence;
    logic       illegal;
    logic [1:0] wr_sel;
    logic [3:0] aluop;
  } ctrl_t;

  typedef enum logic {
    RUN        = 1'b0,
    FENCE_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational RV32 instruction to control bundle decode
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter logic ENABLE_M   = 1'b1,
  parameter logic ENABLE_CSR = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opc;
  logic j, b, u, ld, st, r, i, sys, fen;
  logic mext, sub, legal;
  logic unused_bits;

  assign opc = instr[6:0];
  assign j   = (opc == OPC_JAL) || (opc == OPC_JALR);
  assign b   = (opc == OPC_BRANCH);
  assign u   = (opc == OPC_LUI) || (opc == OPC_AUIPC);
  assign ld  = (opc == OPC_LOAD);
  assign st  = (opc == OPC_STORE);
  assign r   = (opc == OPC_OP);
  assign i   = (opc == OPC_OPIMM);
  assign sys = (opc == OPC_SYSTEM);
  assign fen = (opc == OPC_FENCE);

  assign mext  = r && (instr[31:25] == 7'b0000001) && ENABLE_M;
  assign sub   = r && instr[30] && (instr[14:12] == 3'b000) && !mext;
  // M-ext encodings are only legal when the multiplier exists
  assign legal = j || b || u || ld || st || i || fen || (sys && ENABLE_CSR) ||
                 (r && (ENABLE_M || (instr[31:25] != 7'b0000001)));

  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl = '0;
    if (legal) begin
      ctrl.imsel    = {u || st, i || u || j || ld};
      ctrl.jump     = j;
      ctrl.branch   = b;
      ctrl.alusrc1  = u;
      ctrl.alusrc2  = !(b || r);
      ctrl.regwrite = j || u || ld || r || i || sys;
      ctrl.memread  = ld;
      ctrl.memwrite = st;
      ctrl.h_sel    = j && instr[3];
      ctrl.csr      = sys;
      ctrl.fence    = fen;
      ctrl.wr_sel   = {sys || j || (u && instr[5]), j || ld || st};
      // classes are one-hot, so a priority mux reproduces the per-bit rules
      if (mext)         ctrl.aluop = ALUOP_MEXT;
      else if (ld)      ctrl.aluop = ALUOP_LOAD;
      else if (st)      ctrl.aluop = ALUOP_STORE;
      else if (b || sub) ctrl.aluop = ALUOP_SUB;
      else if (sys)     ctrl.aluop = ALUOP_SYS;
      else if (u || j)  ctrl.aluop = ALUOP_ADDR;
      else              ctrl.aluop = ALUOP_OP;
    end else begin
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered decode stage with handshake, flush and FENCE drain stall
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter logic ENABLE_M   = 1'b1,
  parameter logic ENABLE_CSR = 1'b1,
  parameter int   XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            drain_done,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [1:0]      imsel,
  output logic            jump,
  output logic            branch,
  output logic            alusrc1,
  output logic            alusrc2,
  output logic            regwrite,
  output logic            memread,
  output logic            memwrite,
  output logic            h_sel,
  output logic            csr,
  output logic            fence,
  output logic            illegal,
  output logic [1:0]      wr_sel,
  output logic [3:0]      aluop,
  output logic            fence_busy
);

  ctrl_t  dec, out_q;
  state_t state, state_nxt;
  logic   accept;

  ctrl_decode_comb #(
    .ENABLE_M  (ENABLE_M),
    .ENABLE_CSR(ENABLE_CSR)
  ) u_decode (
    .instr(instr),
    .ctrl (dec)
  );

  assign accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        if (accept && dec.fence) state_nxt = FENCE_WAIT;
      FENCE_WAIT: if (flush || drain_done) state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  always_comb begin
    in_ready   = reset && (state == RUN) && (!out_valid || ex_ready);
    fence_busy = (state == FENCE_WAIT);
  end

  // flush only kills validity; the stale bundle is never presented as valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= dec;
      out_pc    <= pc;
    end else if (ex_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign imsel    = out_q.imsel;
  assign jump     = out_q.jump;
  assign branch   = out_q.branch;
  assign alusrc1  = out_q.alusrc1;
  assign alusrc2  = out_q.alusrc2;
  assign regwrite = out_q.regwrite;
  assign memread  = out_q.memread;
  assign memwrite = out_q.memwrite;
  assign h_sel    = out_q.h_sel;
  assign csr      = out_q.csr;
  assign fence    = out_q.fence;
  assign illegal  = out_q.illegal;
  assign wr_sel   = out_q.wr_sel;
  assign aluop    = out_q.aluop;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - randomized and directed bench for ctrl_decode_pipe against a behavioural model
module tb_ctrl_decode_pipe;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, flush, ex_ready, drain_done;
  logic [31:0] instr, pc;

  logic        m_in_ready, m_out_valid, m_jump, m_branch, m_alusrc1, m_alusrc2, m_regwrite;
  logic        m_memread, m_memwrite, m_h_sel, m_csr, m_fence, m_illegal, m_fence_busy;
  logic [31:0] m_out_pc;
  logic [1:0]  m_imsel, m_wr_sel;
  logic [3:0]  m_aluop;
  logic        n_in_ready, n_out_valid, n_jump, n_branch, n_alusrc1, n_alusrc2, n_regwrite;
  logic        n_memread, n_memwrite, n_h_sel, n_csr, n_fence, n_illegal, n_fence_busy;
  logic [31:0] n_out_pc;
  logic [1:0]  n_imsel, n_wr_sel;
  logic [3:0]  n_aluop;

  ctrl_decode_pipe #(.ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .XLEN(32)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready), .instr(instr),
    .pc(pc), .flush(flush), .ex_ready(ex_ready), .drain_done(drain_done),
    .out_valid(m_out_valid), .out_pc(m_out_pc), .imsel(m_imsel), .jump(m_jump),
    .branch(m_branch), .alusrc1(m_alusrc1), .alusrc2(m_alusrc2), .regwrite(m_regwrite),
    .memread(m_memread), .memwrite(m_memwrite), .h_sel(m_h_sel), .csr(m_csr),
    .fence(m_fence), .illegal(m_illegal), .wr_sel(m_wr_sel), .aluop(m_aluop),
    .fence_busy(m_fence_busy)
  );

  ctrl_decode_pipe #(.ENABLE_M(1'b0), .ENABLE_CSR(1'b0), .XLEN(32)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .instr(instr),
    .pc(pc), .flush(flush), .ex_ready(ex_ready), .drain_done(drain_done),
    .out_valid(n_out_valid), .out_pc(n_out_pc), .imsel(n_imsel), .jump(n_jump),
    .branch(n_branch), .alusrc1(n_alusrc1), .alusrc2(n_alusrc2), .regwrite(n_regwrite),
    .memread(n_memread), .memwrite(n_memwrite), .h_sel(n_h_sel), .csr(n_csr),
    .fence(n_fence), .illegal(n_illegal), .wr_sel(n_wr_sel), .aluop(n_aluop),
    .fence_busy(n_fence_busy)
  );

  ctrl_t act_m, act_n;
  always_comb begin
    act_m = '0;
    act_m.imsel = m_imsel; act_m.jump = m_jump; act_m.branch = m_branch;
    act_m.alusrc1 = m_alusrc1; act_m.alusrc2 = m_alusrc2; act_m.regwrite = m_regwrite;
    act_m.memread = m_memread; act_m.memwrite = m_memwrite; act_m.h_sel = m_h_sel;
    act_m.csr = m_csr; act_m.fence = m_fence; act_m.illegal = m_illegal;
    act_m.wr_sel = m_wr_sel; act_m.aluop = m_aluop;
  end
  always_comb begin
    act_n = '0;
    act_n.imsel = n_imsel; act_n.jump = n_jump; act_n.branch = n_branch;
    act_n.alusrc1 = n_alusrc1; act_n.alusrc2 = n_alusrc2; act_n.regwrite = n_regwrite;
    act_n.memread = n_memread; act_n.memwrite = n_memwrite; act_n.h_sel = n_h_sel;
    act_n.csr = n_csr; act_n.fence = n_fence; act_n.illegal = n_illegal;
    act_n.wr_sel = n_wr_sel; act_n.aluop = n_aluop;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-instruction-class table of what the decoded bundle must be.
  function automatic ctrl_t model(logic [31:0] w, bit en_m, bit en_csr);
    ctrl_t c;
    bit    bad;
    c   = '0;
    bad = 1'b0;
    case (w[6:0])
      7'b1101111, 7'b1100111: begin
        c.jump = 1; c.imsel = 2'b01; c.alusrc2 = 1; c.regwrite = 1;
        c.h_sel = w[3]; c.wr_sel = 2'b11; c.aluop = 4'b0001;
      end
      7'b1100011: begin c.branch = 1; c.aluop = 4'b0101; end
      7'b0110111, 7'b0010111: begin
        c.imsel = 2'b11; c.alusrc1 = 1; c.alusrc2 = 1; c.regwrite = 1;
        c.wr_sel = w[5] ? 2'b10 : 2'b00; c.aluop = 4'b0001;
      end
      7'b0000011: begin
        c.imsel = 2'b01; c.alusrc2 = 1; c.regwrite = 1; c.memread = 1;
        c.wr_sel = 2'b01; c.aluop = 4'b0011;
      end
      7'b0100011: begin
        c.imsel = 2'b10; c.alusrc2 = 1; c.memwrite = 1; c.wr_sel = 2'b01; c.aluop = 4'b0010;
      end
      7'b0110011: begin
        c.regwrite = 1;
        if (w[31:25] == 7'b0000001) begin
          if (en_m) c.aluop = 4'b1000;
          else      bad = 1'b1;
        end else if (w[30] && w[14:12] == 3'b000) begin
          c.aluop = 4'b0101;
        end
      end
      7'b0010011: begin c.imsel = 2'b01; c.alusrc2 = 1; c.regwrite = 1; end
      7'b1110011: begin
        if (!en_csr) bad = 1'b1;
        c.alusrc2 = 1; c.regwrite = 1; c.csr = 1; c.wr_sel = 2'b10; c.aluop = 4'b0100;
      end
      7'b0001111: begin c.alusrc2 = 1; c.fence = 1; end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  // Cycle-level expectation of the output register and the drain stall
  bit          started = 0;
  bit          ev = 0, fw = 0, zero_f = 1;
  logic [31:0] epc = '0;
  ctrl_t       em = '0, en = '0;
  bit          mdl_rdy, mdl_acc;

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      ev = 0; fw = 0; zero_f = 1; epc = '0; em = '0; en = '0;
    end else begin
      mdl_rdy = !fw && (!ev || ex_ready);
      mdl_acc = in_valid && mdl_rdy && !flush;
      if (flush) begin
        ev = 0; fw = 0;
      end else if (mdl_acc) begin
        ev = 1; epc = pc; zero_f = 0;
        em = model(instr, 1, 1);
        en = model(instr, 0, 0);
        if (em.fence) fw = 1;
      end else begin
        if (ex_ready) ev = 0;
        if (fw && drain_done) fw = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready_m", m_in_ready, reset && !fw && (!ev || ex_ready));
      check("in_ready_n", n_in_ready, reset && !fw && (!ev || ex_ready));
      check("out_valid_m", m_out_valid, ev);
      check("out_valid_n", n_out_valid, ev);
      check("fence_busy_m", m_fence_busy, fw);
      check("fence_busy_n", n_fence_busy, fw);
      if (ev || zero_f) begin
        check("ctrl_m", act_m, em);
        check("ctrl_n", act_n, en);
        check("out_pc_m", m_out_pc, epc);
        check("out_pc_n", n_out_pc, epc);
      end
    end
  end

  task automatic drive(bit v, logic [31:0] w, logic [31:0] p, bit fl, bit er, bit dd);
    in_valid = v; instr = w; pc = p; flush = fl; ex_ready = er; drain_done = dd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] w;
    ops = '{7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111, 7'b0000011,
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1110011, 7'b0001111};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 0) w[14:12] = 3'b000;
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'b0000000;
        1: w[31:25] = 7'b0100000;
        2: w[31:25] = 7'b0000001;
        default: ;
      endcase
    end
    return w;
  endfunction

  localparam logic [31:0] I_ADD   = 32'h00B50533;
  localparam logic [31:0] I_SUB   = 32'h40B50533;
  localparam logic [31:0] I_MUL   = 32'h02B50533;
  localparam logic [31:0] I_LW    = 32'h0005A503;
  localparam logic [31:0] I_SW    = 32'h00A5A023;
  localparam logic [31:0] I_FENCE = 32'h0FF0000F;
  localparam logic [31:0] I_CSR   = 32'h30002573;

  ctrl_t lit;

  initial begin
    lit = '0; lit.regwrite = 1;
    check("model_add", model(I_ADD, 1, 1), lit);
    lit = '0; lit.imsel = 2'b10; lit.alusrc2 = 1; lit.memwrite = 1; lit.wr_sel = 2'b01; lit.aluop = 4'b0010;
    check("model_sw", model(I_SW, 1, 1), lit);
    lit = '0; lit.illegal = 1;
    check("model_mul_nom", model(I_MUL, 0, 0), lit);

    reset = 0;
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    step(); step();
    check("rst_in_ready", m_in_ready, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_fence_busy", m_fence_busy, 0);
    check("rst_ctrl", act_m, 0);

    reset = 1;
    drive(1, I_ADD, 32'h100, 0, 1, 0); step();
    check("add_valid", m_out_valid, 1);
    check("add_regwrite", m_regwrite, 1);
    check("add_alusrc2", m_alusrc2, 0);
    check("add_aluop", m_aluop, 4'b0000);
    check("add_imsel", m_imsel, 2'b00);
    check("add_pc", m_out_pc, 32'h100);

    drive(1, I_SUB, 32'h104, 0, 1, 0); step();
    check("sub_aluop", m_aluop, 4'b0101);
    drive(1, I_MUL, 32'h108, 0, 1, 0); step();
    check("mul_aluop_m", m_aluop, 4'b1000);
    check("mul_illegal_m", m_illegal, 0);
    check("mul_illegal_n", n_illegal, 1);
    check("mul_regwrite_n", n_regwrite, 0);

    drive(1, I_LW, 32'h10C, 0, 1, 0); step();
    drive(1, I_SW, 32'h110, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("lw_memread", m_memread, 1);
      check("lw_wr_sel", m_wr_sel, 2'b01);
      check("lw_in_ready", m_in_ready, 0);
      check("lw_pc", m_out_pc, 32'h10C);
    end
    drive(1, I_SW, 32'h110, 0, 1, 0); step();
    check("sw_memwrite", m_memwrite, 1);
    check("sw_regwrite", m_regwrite, 0);
    check("sw_imsel", m_imsel, 2'b10);
    check("sw_pc", m_out_pc, 32'h110);

    drive(1, I_FENCE, 32'h114, 0, 1, 0); step();
    check("fence_out", m_fence, 1);
    check("fence_busy", m_fence_busy, 1);
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("fence_stall_ready", m_in_ready, 0);
    end
    drive(0, 32'h0, 32'h0, 0, 1, 1); step();
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    check("drain_ready", m_in_ready, 1);
    check("drain_busy", m_fence_busy, 0);

    drive(1, I_FENCE, 32'h118, 0, 1, 0); step();
    drive(0, 32'h0, 32'h0, 0, 1, 0); step(); step();
    drive(0, 32'h0, 32'h0, 1, 1, 0); step();
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    check("fflush_ready", m_in_ready, 1);
    check("fflush_busy", m_fence_busy, 0);

    drive(1, I_ADD, 32'h200, 0, 1, 0); step();
    drive(1, I_LW, 32'h204, 1, 0, 0); step();
    check("flush_valid", m_out_valid, 0);
    drive(0, 32'h0, 32'h0, 0, 1, 0); step();
    check("flush_dropped", m_out_valid, 0);

    drive(1, 32'h0000007F, 32'h300, 0, 1, 0); step();
    check("ill7f_illegal", m_illegal, 1);
    check("ill7f_valid", m_out_valid, 1);
    check("ill7f_pc", m_out_pc, 32'h300);
    check("ill7f_side", {m_regwrite, m_memread, m_memwrite, m_jump, m_branch, m_csr, m_fence}, 0);
    drive(1, 32'h00B50530, 32'h304, 0, 1, 0); step();
    check("ill00_illegal", m_illegal, 1);
    check("ill00_pc", m_out_pc, 32'h304);
    drive(1, I_CSR, 32'h308, 0, 1, 0); step();
    check("csr_m", m_csr, 1);
    check("csr_n_illegal", n_illegal, 1);

    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom,
            $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
      step();
    end
    reset = 1;
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
